// File: rtl/sample_capture_ctrl.sv
// Sample capture sequencer: FIFO reset, rate divider, channel packing, overflow.
// Optional word-count limit (limit/done ports) enabled by defining SAMPLE_LIMIT_EN.
module sample_capture_ctrl #(
    parameter int DIV_W      = 16,
    parameter int RST_CYCLES = 8
`ifdef SAMPLE_LIMIT_EN
    ,
    parameter int CNT_W      = 24
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [DIV_W-1:0] divider,
    input  logic [1:0]       mode,
    input  logic [15:0]      probe,
    input  logic             fifo_full,
`ifdef SAMPLE_LIMIT_EN
    input  logic [CNT_W-1:0] limit,
    output logic             done,
`endif
    output logic             fifo_rst,
    output logic [15:0]      sample_data,
    output logic             sample_data_avail,
    output logic             running,
    output logic             overflow
);

    localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RCW-1:0] RLAST = RCW'(RST_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FRST,
        S_ARM,
        S_RUN,
        S_HALT
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [RCW-1:0]   rcnt;
    logic [DIV_W-1:0] dcnt;
    logic [DIV_W-1:0] div_q;
    logic [1:0]       mode_q;
    logic [1:0]       idx;
    logic [1:0]       idx_n;
    logic [15:0]      pack;
    logic [15:0]      word;
    logic             tick;
    logic             wr;
    logic             lim_hit;

`ifdef SAMPLE_LIMIT_EN
    logic [CNT_W-1:0] limit_q;
    logic [CNT_W-1:0] wcnt;
`endif

    // Slot insertion and write decision for the current tick
    always_comb begin
        tick  = (state == S_RUN) && (dcnt == div_q);
        word  = pack;
        idx_n = idx;
        wr    = 1'b0;
        unique case (mode_q)
            2'd1: begin
                if (idx[0]) begin
                    word = {probe[7:0], pack[7:0]};
                end else begin
                    word = {pack[15:8], probe[7:0]};
                end
                idx_n = {1'b0, ~idx[0]};
                wr    = tick && idx[0];
            end
            2'd2: begin
                word[{idx, 2'b00} +: 4] = probe[3:0];
                idx_n = idx + 2'd1;
                wr    = tick && (idx == 2'd3);
            end
            default: begin
                word  = probe;
                idx_n = 2'd0;
                wr    = tick;
            end
        endcase
    end

`ifdef SAMPLE_LIMIT_EN
    always_comb begin
        lim_hit = 1'b0;
        if (wr && (limit_q != '0) && ((wcnt + CNT_W'(1)) == limit_q)) begin
            lim_hit = 1'b1;
        end
    end
`else
    always_comb begin
        lim_hit = 1'b0;
    end
`endif

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_FRST;
                end
            end
            S_FRST: begin
                if (stop) begin
                    state_n = S_IDLE;
                end else if (rcnt == RLAST) begin
                    state_n = S_ARM;
                end
            end
            S_ARM: begin
                state_n = S_RUN;
            end
            S_RUN: begin
                if (stop || (wr && fifo_full) || lim_hit) begin
                    state_n = S_HALT;
                end
            end
            S_HALT: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rcnt              <= '0;
            dcnt              <= '0;
            div_q             <= '0;
            mode_q            <= 2'd0;
            idx               <= 2'd0;
            pack              <= 16'h0;
            sample_data       <= 16'h0;
            sample_data_avail <= 1'b0;
            overflow          <= 1'b0;
`ifdef SAMPLE_LIMIT_EN
            limit_q           <= '0;
            wcnt              <= '0;
            done              <= 1'b0;
`endif
        end else begin
            sample_data_avail <= wr;
            if (wr) begin
                sample_data <= word;
            end
            // The FIFO drops this word; flag it and let the FSM halt
            if (wr && fifo_full) begin
                overflow <= 1'b1;
            end
`ifdef SAMPLE_LIMIT_EN
            if (wr) begin
                wcnt <= wcnt + CNT_W'(1);
            end
            if (lim_hit) begin
                done <= 1'b1;
            end
`endif
            unique case (state)
                S_IDLE: begin
                    rcnt <= '0;
                    if (start) begin
                        div_q    <= divider;
                        mode_q   <= (mode == 2'd3) ? 2'd0 : mode;
                        overflow <= 1'b0;
`ifdef SAMPLE_LIMIT_EN
                        limit_q  <= limit;
                        wcnt     <= '0;
                        done     <= 1'b0;
`endif
                    end
                end
                S_FRST: begin
                    rcnt <= rcnt + 1'b1;
                end
                S_ARM: begin
                    dcnt <= '0;
                    idx  <= 2'd0;
                    pack <= 16'h0;
                end
                S_RUN: begin
                    if (tick) begin
                        dcnt <= '0;
                        pack <= word;
                        idx  <= idx_n;
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign fifo_rst = (state == S_FRST);
    assign running  = (state == S_ARM) || (state == S_RUN);

endmodule
